guess_game_ctrl: RTL and testbench

- Parametrised game controller for the letter-guessing game; generalises the single-player control FSM.
- Adds configurable word length, miss limit and turn timeout; 1–4 alternating players; internal word storage and parallel compare; repeat-guess filtering.
- Sits between the keyboard decoder and the VGA drawing datapath. Drives one draw request per revealed letter or body part over a req/done handshake.

---
 rtl/guess_game_ctrl.sv | 268 ++++++++++++++++++++++++++
 tb/tb_guess_game_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/guess_game_ctrl.sv
// Letter-guessing game controller: word entry, 1..NUM_PLAYERS alternating
// turns, parallel letter compare, repeat-guess filter, turn timeout and a
// req/done draw handshake toward the VGA datapath.
//
// Ports:
//   clk, resetn          clock, async active-low reset
//   key_valid/key_char   letter strobe and code (1..26 valid)
//   key_end/key_start    end of word entry / start play pulses
//   key_wipe             abort to word entry (scores kept)
//   draw_done            datapath finished the current draw
//   draw_req/kind/index  draw request (0 = letter fill, 1 = body part)
//   revealed, word_len   per-position revealed mask, entered word length
//   miss_count           misses so far
//   cur_player, scores   active player, per-player win counts (8 bits each)
//   timeout_flag         one-cycle pulse, high in the first DRAW cycle of a forced miss
//   game_over, win       high in WIN or LOSE / high in WIN
module guess_game_ctrl #(
    parameter int unsigned WORD_LEN    = 8,
    parameter int unsigned MAX_MISS    = 6,
    parameter int unsigned TIMEOUT_CYC = 50000000,
    parameter int unsigned NUM_PLAYERS = 2,
    parameter int unsigned CHAR_W      = 5
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     key_valid,
    input  logic [CHAR_W-1:0]        key_char,
    input  logic                     key_end,
    input  logic                     key_start,
    input  logic                     key_wipe,
    input  logic                     draw_done,
    output logic                     draw_req,
    output logic                     draw_kind,
    output logic [3:0]               draw_index,
    output logic [WORD_LEN-1:0]      revealed,
    output logic [4:0]               word_len,
    output logic [3:0]               miss_count,
    output logic [1:0]               cur_player,
    output logic [8*NUM_PLAYERS-1:0] scores,
    output logic                     timeout_flag,
    output logic                     game_over,
    output logic                     win
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int unsigned SET_W = 1 << CHAR_W;

    typedef enum logic [3:0] {
        S_ENTRY, S_READY, S_GUESS, S_COMPARE, S_FILL,
        S_FILL_WAIT, S_DRAW, S_DRAW_WAIT, S_WIN, S_LOSE
    } state_t;

    state_t                               state_q, state_d;
    logic [WORD_LEN-1:0][CHAR_W-1:0]      word_q, word_d;
    logic [4:0]                           word_len_q, word_len_d;
    logic [WORD_LEN-1:0]                  revealed_q, revealed_d;
    logic [WORD_LEN-1:0]                  hit_q, hit_d;
    logic [CHAR_W-1:0]                    guess_q, guess_d;
    logic [SET_W-1:0]                     guessed_q, guessed_d;
    logic [3:0]                           miss_q, miss_d;
    logic [1:0]                           player_q, player_d;
    logic [NUM_PLAYERS-1:0][7:0]          scores_q, scores_d;
    logic [CNT_W-1:0]                     cnt_q, cnt_d;
    logic                                 draw_req_q, draw_req_d;
    logic                                 draw_kind_q, draw_kind_d;
    logic [3:0]                           draw_index_q, draw_index_d;
    logic                                 timeout_q, timeout_d;
    logic                                 game_over_q, game_over_d;
    logic                                 win_q, win_d;

    logic                                 key_ok_c;
    logic [WORD_LEN-1:0]                  len_mask_c;
    logic [WORD_LEN-1:0]                  hit_c;
    logic [WORD_LEN-1:0]                  low_c;

    // Position of the lowest set bit (0 when the mask is empty).
    function automatic logic [3:0] low_index(input logic [WORD_LEN-1:0] m);
        logic [3:0] idx;
        idx = '0;
        for (int i = WORD_LEN - 1; i >= 0; i--) begin
            if (m[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    // Valid letter strobe, used-position mask, parallel compare, lowest pending hit.
    always_comb begin
        key_ok_c = key_valid && (key_char != '0) && (key_char <= CHAR_W'(26));
        for (int i = 0; i < WORD_LEN; i++) begin
            len_mask_c[i] = (5'(i) < word_len_q);
            hit_c[i]      = (word_q[i] == guess_q) && len_mask_c[i] && !revealed_q[i];
        end
        low_c = hit_q & (~hit_q + WORD_LEN'(1));
    end

    // Next-state and next-register values.
    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        word_len_d  = word_len_q;
        revealed_d  = revealed_q;
        hit_d       = hit_q;
        guess_d     = guess_q;
        guessed_d   = guessed_q;
        miss_d      = miss_q;
        player_d    = player_q;
        scores_d    = scores_q;
        cnt_d       = '0;
        timeout_d   = 1'b0;

        case (state_q)
            S_ENTRY: begin
                if (key_ok_c && (word_len_q < 5'(WORD_LEN))) begin
                    for (int i = 0; i < WORD_LEN; i++) begin
                        if (5'(i) == word_len_q) word_d[i] = key_char;
                    end
                    word_len_d = word_len_q + 5'd1;
                end
                if (key_end && (word_len_q != 5'd0)) begin
                    state_d    = S_READY;
                    player_d   = '0;
                    miss_d     = '0;
                    guessed_d  = '0;
                    revealed_d = '0;
                end
            end
            S_READY: begin
                if (key_start) state_d = S_GUESS;
            end
            S_GUESS: begin
                // A key arriving in the expiry cycle takes precedence.
                if (key_ok_c) begin
                    guess_d = key_char;
                    state_d = S_COMPARE;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    timeout_d = 1'b1;
                    miss_d    = miss_q + 4'd1;
                    state_d   = S_DRAW;
                end
            end
            S_COMPARE: begin
                if (guessed_q[guess_q]) begin
                    state_d = S_GUESS;
                end else begin
                    guessed_d[guess_q] = 1'b1;
                    if (hit_c != '0) begin
                        hit_d   = hit_c;
                        state_d = S_FILL;
                    end else begin
                        miss_d  = miss_q + 4'd1;
                        state_d = S_DRAW;
                    end
                end
            end
            S_FILL: begin
                if (draw_done) begin
                    revealed_d = revealed_q | low_c;
                    hit_d      = hit_q & ~low_c;
                    state_d    = S_FILL_WAIT;
                end
            end
            S_FILL_WAIT: begin
                if (hit_q != '0) begin
                    state_d = S_FILL;
                end else if ((revealed_q & len_mask_c) == len_mask_c) begin
                    state_d = S_WIN;
                    for (int p = 0; p < NUM_PLAYERS; p++) begin
                        if ((2'(p) == player_q) && (scores_q[p] != 8'hFF)) begin
                            scores_d[p] = scores_q[p] + 8'd1;
                        end
                    end
                end else begin
                    state_d = S_GUESS;
                end
            end
            S_DRAW: begin
                if (draw_done) state_d = S_DRAW_WAIT;
            end
            S_DRAW_WAIT: begin
                if (miss_q == 4'(MAX_MISS)) begin
                    state_d = S_LOSE;
                end else begin
                    player_d = (player_q == 2'(NUM_PLAYERS - 1)) ? 2'd0 : player_q + 2'd1;
                    state_d  = S_GUESS;
                end
            end
            S_WIN, S_LOSE: ;
            default: state_d = S_ENTRY;
        endcase

        // Wipe overrides everything decided above except the stored word and scores.
        if (key_wipe) begin
            state_d    = S_ENTRY;
            word_len_d = '0;
            revealed_d = '0;
            hit_d      = '0;
            guessed_d  = '0;
            miss_d     = '0;
            player_d   = '0;
            scores_d   = scores_q;
            timeout_d  = 1'b0;
        end

        // Turn counter restarts on every entry into GUESS.
        if ((state_q == S_GUESS) && (state_d == S_GUESS)) cnt_d = cnt_q + CNT_W'(1);

        draw_req_d   = (state_d == S_FILL) || (state_d == S_DRAW);
        draw_kind_d  = (state_d == S_DRAW);
        draw_index_d = (state_d == S_FILL) ? low_index(hit_d) :
                       (state_d == S_DRAW) ? miss_d - 4'd1 : 4'd0;
        game_over_d  = (state_d == S_WIN) || (state_d == S_LOSE);
        win_d        = (state_d == S_WIN);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_ENTRY;
            word_q       <= '0;
            word_len_q   <= '0;
            revealed_q   <= '0;
            hit_q        <= '0;
            guess_q      <= '0;
            guessed_q    <= '0;
            miss_q       <= '0;
            player_q     <= '0;
            scores_q     <= '0;
            cnt_q        <= '0;
            draw_req_q   <= 1'b0;
            draw_kind_q  <= 1'b0;
            draw_index_q <= '0;
            timeout_q    <= 1'b0;
            game_over_q  <= 1'b0;
            win_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_q       <= word_d;
            word_len_q   <= word_len_d;
            revealed_q   <= revealed_d;
            hit_q        <= hit_d;
            guess_q      <= guess_d;
            guessed_q    <= guessed_d;
            miss_q       <= miss_d;
            player_q     <= player_d;
            scores_q     <= scores_d;
            cnt_q        <= cnt_d;
            draw_req_q   <= draw_req_d;
            draw_kind_q  <= draw_kind_d;
            draw_index_q <= draw_index_d;
            timeout_q    <= timeout_d;
            game_over_q  <= game_over_d;
            win_q        <= win_d;
        end
    end

    assign draw_req     = draw_req_q;
    assign draw_kind    = draw_kind_q;
    assign draw_index   = draw_index_q;
    assign revealed     = revealed_q;
    assign word_len     = word_len_q;
    assign miss_count   = miss_q;
    assign cur_player   = player_q;
    assign scores       = scores_q;
    assign timeout_flag = timeout_q;
    assign game_over    = game_over_q;
    assign win          = win_q;

endmodule

// File: tb/tb_guess_game_ctrl.sv
// Directed bench for guess_game_ctrl (WORD_LEN=8, MAX_MISS=2, TIMEOUT_CYC=16,
// NUM_PLAYERS=2). Letter codes: A=1 B=2 C=3 L=12 Y=25 Z=26.
module tb_guess_game_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        key_valid, key_end, key_start, key_wipe, draw_done;
    logic [4:0]  key_char;
    logic        draw_req, draw_kind, timeout_flag, game_over, win;
    logic [3:0]  draw_index, miss_count;
    logic [7:0]  revealed;
    logic [4:0]  word_len;
    logic [1:0]  cur_player;
    logic [15:0] scores;

    int vectors = 0;
    int miscompares = 0;

    guess_game_ctrl #(
        .WORD_LEN(8), .MAX_MISS(2), .TIMEOUT_CYC(16), .NUM_PLAYERS(2), .CHAR_W(5)
    ) dut (
        .clk(clk), .resetn(resetn), .key_valid(key_valid), .key_char(key_char),
        .key_end(key_end), .key_start(key_start), .key_wipe(key_wipe),
        .draw_done(draw_done), .draw_req(draw_req), .draw_kind(draw_kind),
        .draw_index(draw_index), .revealed(revealed), .word_len(word_len),
        .miss_count(miss_count), .cur_player(cur_player), .scores(scores),
        .timeout_flag(timeout_flag), .game_over(game_over), .win(win)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press_key(input logic [4:0] c);
        key_valid = 1'b1; key_char = c; step(); key_valid = 1'b0; key_char = '0;
    endtask

    task automatic press_end();
        key_end = 1'b1; step(); key_end = 1'b0;
    endtask

    task automatic press_start();
        key_start = 1'b1; step(); key_start = 1'b0;
    endtask

    task automatic press_wipe();
        key_wipe = 1'b1; step(); key_wipe = 1'b0;
    endtask

    task automatic ack();
        draw_done = 1'b1; step(); draw_done = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #12;
        vectors++;
        if ({draw_req, draw_kind, draw_index, revealed, word_len, miss_count, cur_player,
             scores, timeout_flag, game_over, win} !== 50'd0) begin
            miscompares++; $display("FAIL reset_outputs: some output nonzero during reset");
        end
        step();
        resetn = 1'b1;
        step();
    endtask

    task automatic test_entry_limits();
        press_end();
        press_key(5'd0);
        press_key(5'd27);
        vectors++;
        if (word_len !== 5'd0) begin
            miscompares++; $display("FAIL entry_invalid_or_empty_end: got %0d expected 0", word_len);
        end
        for (int i = 1; i <= 9; i++) press_key(5'(i));
        vectors++;
        if (word_len !== 5'd8) begin
            miscompares++; $display("FAIL entry_overflow: got %0d expected 8", word_len);
        end
        press_wipe();
        vectors++;
        if (word_len !== 5'd0) begin
            miscompares++; $display("FAIL entry_wipe: got %0d expected 0", word_len);
        end
    endtask

    task automatic test_single_fill();
        press_key(5'd3); press_key(5'd1); press_key(5'd2);
        press_end(); press_start();
        press_key(5'd1);
        vectors++;
        if (draw_req !== 1'b0) begin
            miscompares++; $display("FAIL cab_compare_req: got %0b expected 0", draw_req);
        end
        step();
        vectors++;
        if ({draw_req, draw_kind, draw_index} !== {1'b1, 1'b0, 4'd1}) begin
            miscompares++; $display("FAIL cab_fill: got req=%0b kind=%0b idx=%0d expected 1 0 1",
                                    draw_req, draw_kind, draw_index);
        end
        step(); step();
        vectors++;
        if ({draw_req, draw_kind, draw_index} !== {1'b1, 1'b0, 4'd1}) begin
            miscompares++; $display("FAIL cab_fill_hold: got req=%0b kind=%0b idx=%0d expected 1 0 1",
                                    draw_req, draw_kind, draw_index);
        end
        ack();
        vectors++;
        if (draw_req !== 1'b0) begin
            miscompares++; $display("FAIL cab_fill_release: got %0b expected 0", draw_req);
        end
        step();
        vectors++;
        if ({revealed, cur_player, miss_count, draw_req} !== {8'b0000_0010, 2'd0, 4'd0, 1'b0}) begin
            miscompares++; $display("FAIL cab_after_fill: got rev=%b pl=%0d miss=%0d req=%0b expected 00000010 0 0 0",
                                    revealed, cur_player, miss_count, draw_req);
        end
    endtask

    task automatic test_repeat_guess();
        press_key(5'd1);
        step();
        vectors++;
        if ({draw_req, miss_count} !== {1'b0, 4'd0}) begin
            miscompares++; $display("FAIL repeat_no_effect: got req=%0b miss=%0d expected 0 0",
                                    draw_req, miss_count);
        end
        press_key(5'd26);
        step();
        vectors++;
        if ({draw_req, draw_kind, draw_index, miss_count} !== {1'b1, 1'b1, 4'd0, 4'd1}) begin
            miscompares++; $display("FAIL miss1_draw: got req=%0b kind=%0b idx=%0d miss=%0d expected 1 1 0 1",
                                    draw_req, draw_kind, draw_index, miss_count);
        end
        ack();
        step();
        vectors++;
        if ({cur_player, draw_req} !== {2'd1, 1'b0}) begin
            miscompares++; $display("FAIL miss1_turn: got pl=%0d req=%0b expected 1 0", cur_player, draw_req);
        end
    endtask

    task automatic test_lose();
        press_key(5'd25);
        step();
        vectors++;
        if ({draw_req, draw_kind, draw_index, miss_count} !== {1'b1, 1'b1, 4'd1, 4'd2}) begin
            miscompares++; $display("FAIL miss2_draw: got req=%0b kind=%0b idx=%0d miss=%0d expected 1 1 1 2",
                                    draw_req, draw_kind, draw_index, miss_count);
        end
        ack();
        step();
        vectors++;
        if ({game_over, win, scores, cur_player} !== {1'b1, 1'b0, 16'd0, 2'd1}) begin
            miscompares++; $display("FAIL lose_state: got go=%0b win=%0b scores=%0h pl=%0d expected 1 0 0 1",
                                    game_over, win, scores, cur_player);
        end
    endtask

    task automatic test_win_alla();
        press_wipe();
        press_key(5'd1); press_key(5'd12); press_key(5'd12); press_key(5'd1);
        press_end(); press_start();
        press_key(5'd1);
        step();
        vectors++;
        if ({draw_req, draw_index} !== {1'b1, 4'd0}) begin
            miscompares++; $display("FAIL alla_fill0: got req=%0b idx=%0d expected 1 0", draw_req, draw_index);
        end
        ack();
        vectors++;
        if (draw_req !== 1'b0) begin
            miscompares++; $display("FAIL alla_gap0: got %0b expected 0", draw_req);
        end
        step();
        vectors++;
        if ({draw_req, draw_index} !== {1'b1, 4'd3}) begin
            miscompares++; $display("FAIL alla_fill3: got req=%0b idx=%0d expected 1 3", draw_req, draw_index);
        end
        ack(); step();
        vectors++;
        if (revealed !== 8'b0000_1001) begin
            miscompares++; $display("FAIL alla_rev_a: got %b expected 00001001", revealed);
        end
        press_key(5'd12);
        step();
        vectors++;
        if ({draw_req, draw_index} !== {1'b1, 4'd1}) begin
            miscompares++; $display("FAIL alla_fill1: got req=%0b idx=%0d expected 1 1", draw_req, draw_index);
        end
        ack();
        vectors++;
        if (draw_req !== 1'b0) begin
            miscompares++; $display("FAIL alla_gap1: got %0b expected 0", draw_req);
        end
        step();
        vectors++;
        if ({draw_req, draw_index} !== {1'b1, 4'd2}) begin
            miscompares++; $display("FAIL alla_fill2: got req=%0b idx=%0d expected 1 2", draw_req, draw_index);
        end
        ack(); step();
        vectors++;
        if ({game_over, win, scores, revealed} !== {1'b1, 1'b1, 16'h0001, 8'b0000_1111}) begin
            miscompares++; $display("FAIL alla_win: got go=%0b win=%0b scores=%0h rev=%b expected 1 1 0001 00001111",
                                    game_over, win, scores, revealed);
        end
    endtask

    task automatic test_timeout();
        int n;
        press_wipe();
        press_key(5'd1); press_end(); press_start();
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (timeout_flag === 1'b1) begin
                n = i;
                break;
            end
        end
        vectors++;
        if (n != 16) begin
            miscompares++; $display("FAIL timeout_latency: got %0d cycles expected 16 (0 = never)", n);
        end
        vectors++;
        if ({draw_req, draw_kind, draw_index, miss_count} !== {1'b1, 1'b1, 4'd0, 4'd1}) begin
            miscompares++; $display("FAIL timeout_draw: got req=%0b kind=%0b idx=%0d miss=%0d expected 1 1 0 1",
                                    draw_req, draw_kind, draw_index, miss_count);
        end
        step();
        vectors++;
        if ({timeout_flag, draw_req} !== {1'b0, 1'b1}) begin
            miscompares++; $display("FAIL timeout_pulse: got flag=%0b req=%0b expected 0 1", timeout_flag, draw_req);
        end
        ack(); step();
        vectors++;
        if (cur_player !== 2'd1) begin
            miscompares++; $display("FAIL timeout_turn: got %0d expected 1", cur_player);
        end
    endtask

    task automatic test_wipe_during_draw();
        press_key(5'd2);
        step();
        vectors++;
        if (draw_req !== 1'b1) begin
            miscompares++; $display("FAIL wipe_pre_req: got %0b expected 1", draw_req);
        end
        key_wipe = 1'b1; draw_done = 1'b1;
        step();
        key_wipe = 1'b0; draw_done = 1'b0;
        vectors++;
        if ({draw_req, word_len, miss_count, cur_player, revealed, game_over, scores} !==
            {1'b0, 5'd0, 4'd0, 2'd0, 8'd0, 1'b0, 16'h0001}) begin
            miscompares++; $display("FAIL wipe_clear: got req=%0b len=%0d miss=%0d pl=%0d rev=%b go=%0b scores=%0h expected 0 0 0 0 0 0 0001",
                                    draw_req, word_len, miss_count, cur_player, revealed, game_over, scores);
        end
    endtask

    task automatic test_reset_mid_fill();
        press_key(5'd1); press_end(); press_start();
        press_key(5'd1);
        step();
        vectors++;
        if (draw_req !== 1'b1) begin
            miscompares++; $display("FAIL rst_pre_req: got %0b expected 1", draw_req);
        end
        resetn = 1'b0;
        #2;
        vectors++;
        if ({draw_req, scores, word_len, revealed, miss_count} !== {1'b0, 16'd0, 5'd0, 8'd0, 4'd0}) begin
            miscompares++; $display("FAIL rst_mid_fill: got req=%0b scores=%0h len=%0d rev=%b miss=%0d expected all 0",
                                    draw_req, scores, word_len, revealed, miss_count);
        end
        step();
        resetn = 1'b1;
        step();
        press_key(5'd7);
        vectors++;
        if (word_len !== 5'd1) begin
            miscompares++; $display("FAIL rst_back_in_entry: got %0d expected 1", word_len);
        end
    endtask

    initial begin
        resetn = 1'b0; key_valid = 1'b0; key_char = '0; key_end = 1'b0;
        key_start = 1'b0; key_wipe = 1'b0; draw_done = 1'b0;
        test_reset();
        test_entry_limits();
        test_single_fill();
        test_repeat_guess();
        test_lose();
        test_win_alla();
        test_timeout();
        test_wipe_during_draw();
        test_reset_mid_fill();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
